// File: rtl/reg_file_hs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : reg_file_pkg                                                 |
// | Description : Shared types, default parameter values and helper function   |
// |               for the handshaked register file.                            |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package reg_file_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      ACK  = 2'd2
   } state_t;

   localparam int c_DEF_DW    = 32;
   localparam int c_DEF_DEPTH = 16;
   localparam int c_DEF_LAT   = 11;

   // Bits needed to hold values 0..n-1; never returns less than 1 so that
   // single-entry cases still produce a legal vector width.
   function automatic int ceil_log2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_hs_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : reg_file_hs_if                                               |
// | Description : Packed multi-port read/write request bus with per-port        |
// |               req/ack handshakes.                                          |
// | Ports       : rd_req/rd_addr/rd_data/rd_ack, wr_req/wr_addr/wr_data/wr_ack  |
// |               master = requester side, slave = register file side          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface reg_file_hs_if #(
   parameter int DW  = 32,
   parameter int AW  = 4,
   parameter int NRD = 4,
   parameter int NWR = 4
);
   logic [NRD-1:0]    rd_req;
   logic [NRD*AW-1:0] rd_addr;
   logic [NRD*DW-1:0] rd_data;
   logic [NRD-1:0]    rd_ack;
   logic [NWR-1:0]    wr_req;
   logic [NWR*AW-1:0] wr_addr;
   logic [NWR*DW-1:0] wr_data;
   logic [NWR-1:0]    wr_ack;

   modport master (
      output rd_req, rd_addr, wr_req, wr_addr, wr_data,
      input  rd_data, rd_ack, wr_ack
   );

   modport slave (
      input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
      output rd_data, rd_ack, wr_ack
   );
endinterface
`default_nettype wire

// File: rtl/reg_file_hs_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_arbiter                                                   |
// | Description : Round-robin arbiter. Combinational search starting one past  |
// |               the last granted index, with a registered search pointer.    |
// | Ports       : clk, rst, req[N], enable, update -> grant (one-hot),         |
// |               idx (binary), valid                                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rr_arbiter
   import reg_file_pkg::*;
#(
   parameter  int N  = 8,
   localparam int IW = ceil_log2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   input  logic          enable,
   input  logic          update,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          valid
);

   // Search start index: 0 after reset, then last_grant + 1 (mod N).
   logic [IW-1:0] r_ptr;
   int            w_j;

   // Walk from the farthest candidate back to the pointer so the candidate
   // nearest the pointer overwrites any earlier hit.
   always_comb begin
      grant = '0;
      idx   = '0;
      valid = 1'b0;
      w_j   = 0;
      for (int k = N - 1; k >= 0; k--) begin
         w_j = int'(r_ptr) + k;
         if (w_j >= N) w_j = w_j - N;
         if (enable && req[w_j]) begin
            grant      = '0;
            grant[w_j] = 1'b1;
            idx        = IW'(w_j);
            valid      = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (update) begin
         r_ptr <= (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/reg_file_hs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : reg_file_hs                                                  |
// | Description : Parametrised register file with NRD read and NWR write ports |
// |               served one at a time through a round-robin arbiter and a     |
// |               LAT-cycle access engine; PC and CPSR sit beside the array.   |
// | Ports       : clk, rst                                                     |
// |               bus (slave)  : per-port req/addr/data/ack handshakes         |
// |               pc_we/pc_din/pc, cpsr_we/cpsr_din/cpsr : direct-load regs    |
// |               busy         : access engine not idle                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module reg_file_hs
   import reg_file_pkg::*;
#(
   parameter int DW    = c_DEF_DW,
   parameter int DEPTH = c_DEF_DEPTH,
   parameter int AW    = $clog2(DEPTH),
   parameter int NRD   = 4,
   parameter int NWR   = 4,
   parameter int LAT   = c_DEF_LAT
) (
   input  logic          clk,
   input  logic          rst,
   reg_file_hs_if.slave  bus,
   input  logic          pc_we,
   input  logic [DW-1:0] pc_din,
   output logic [DW-1:0] pc,
   input  logic          cpsr_we,
   input  logic [DW-1:0] cpsr_din,
   output logic [DW-1:0] cpsr,
   output logic          busy
);

   localparam int c_NREQ = NRD + NWR;
   localparam int c_IW   = ceil_log2(c_NREQ);
   localparam int c_RPW  = ceil_log2(NRD);
   localparam int c_WPW  = ceil_log2(NWR);
   localparam int c_CW   = ceil_log2(LAT);

   state_t            r_state;
   state_t            w_next_state;
   logic [c_CW-1:0]   r_cnt;
   logic [c_IW-1:0]   r_gnt_idx;
   logic [c_NREQ-1:0] r_gnt_oh;
   logic [NRD-1:0]    r_rd_ack;
   logic [NWR-1:0]    r_wr_ack;
   logic [DW-1:0]     r_mem     [DEPTH];
   logic [DW-1:0]     r_rd_data [NRD];

   logic [AW-1:0]     w_rd_addr [NRD];
   logic [AW-1:0]     w_wr_addr [NWR];
   logic [DW-1:0]     w_wr_data [NWR];

   logic [c_NREQ-1:0] w_req;
   logic [c_NREQ-1:0] w_gnt_oh;
   logic [c_IW-1:0]   w_gnt_idx;
   logic              w_gnt_valid;
   logic              w_arb_en;
   logic              w_commit;
   logic              w_cnt_dec;
   logic              w_is_rd;
   logic [c_RPW-1:0]  w_rport;
   logic [c_WPW-1:0]  w_wport;
   logic [AW-1:0]     w_addr;
   logic              w_in_range;

   // ---- port unpacking ----
   for (genvar i = 0; i < NRD; i++) begin : g_rd
      assign w_rd_addr[i]             = bus.rd_addr[i*AW +: AW];
      assign bus.rd_data[i*DW +: DW]  = r_rd_data[i];
   end

   for (genvar i = 0; i < NWR; i++) begin : g_wr
      assign w_wr_addr[i] = bus.wr_addr[i*AW +: AW];
      assign w_wr_data[i] = bus.wr_data[i*DW +: DW];
   end

   assign bus.rd_ack = r_rd_ack;
   assign bus.wr_ack = r_wr_ack;

   // Requestor order: reads occupy the low indices, writes the high ones.
   assign w_req = {bus.wr_req, bus.rd_req};

   rr_arbiter #(.N(c_NREQ)) u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    (w_req),
      .enable (w_arb_en),
      .update (w_gnt_valid),
      .grant  (w_gnt_oh),
      .idx    (w_gnt_idx),
      .valid  (w_gnt_valid)
   );

   // ---- decode of the latched grant ----
   assign w_is_rd = |r_gnt_oh[NRD-1:0];
   assign w_rport = c_RPW'(r_gnt_idx);
   assign w_wport = c_WPW'(r_gnt_idx - c_IW'(NRD));
   assign w_addr  = w_is_rd ? w_rd_addr[w_rport] : w_wr_addr[w_wport];

   // With a power-of-two depth every address is valid, so no compare is built.
   if (DEPTH == (1 << AW)) begin : g_full
      assign w_in_range = 1'b1;
   end else begin : g_part
      assign w_in_range = (w_addr < AW'(DEPTH));
   end

   // ---- FSM: state register ----
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next_state;
   end

   // ---- FSM: next state ----
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_gnt_valid) w_next_state = BUSY;
         BUSY:    if (r_cnt == '0) w_next_state = ACK;
         ACK:     w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // ---- FSM: outputs ----
   always_comb begin
      w_arb_en  = (r_state == IDLE);
      w_commit  = (r_state == BUSY) && (r_cnt == '0);
      w_cnt_dec = (r_state == BUSY) && (r_cnt != '0);
      busy      = (r_state != IDLE);
   end

   // ---- access engine datapath ----
   // Acks are cleared every cycle and set only on the commit edge, which makes
   // them single-cycle pulses and guarantees at most one is high at a time.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         for (int i = 0; i < NRD; i++)   r_rd_data[i] <= '0;
         r_rd_ack  <= '0;
         r_wr_ack  <= '0;
         r_gnt_idx <= '0;
         r_gnt_oh  <= '0;
         r_cnt     <= '0;
      end else begin
         r_rd_ack <= '0;
         r_wr_ack <= '0;
         if (w_gnt_valid) begin
            r_gnt_idx <= w_gnt_idx;
            r_gnt_oh  <= w_gnt_oh;
            r_cnt     <= c_CW'(LAT - 1);
         end else if (w_cnt_dec) begin
            r_cnt <= r_cnt - c_CW'(1);
         end
         if (w_commit) begin
            if (w_is_rd) begin
               r_rd_data[w_rport] <= w_in_range ? r_mem[w_addr] : '0;
               r_rd_ack[w_rport]  <= 1'b1;
            end else begin
               if (w_in_range) r_mem[w_addr] <= w_wr_data[w_wport];
               r_wr_ack[w_wport] <= 1'b1;
            end
         end
      end
   end

   // ---- PC / CPSR: independent of the access engine ----
   always_ff @(posedge clk) begin
      if (rst) begin
         pc   <= '0;
         cpsr <= '0;
      end else begin
         if (pc_we)   pc   <= pc_din;
         if (cpsr_we) cpsr <= cpsr_din;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_hs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_reg_file_hs                                               |
// | Description : Directed self-checking bench for reg_file_hs: a 16-entry     |
// |               instance and a 12-entry instance for out-of-range addresses. |
// | Ports       : none                                                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_reg_file_hs;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pc_we = 1'b0,   cpsr_we = 1'b0;
   logic [31:0] pc_din = '0,    cpsr_din = '0;
   logic [31:0] pc, cpsr;
   logic        busy;
   logic        pc_we12 = 1'b0, cpsr_we12 = 1'b0;
   logic [31:0] pc_din12 = '0,  cpsr_din12 = '0;
   logic [31:0] pc12, cpsr12;
   logic        busy12;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   reg_file_hs_if #(.DW(32), .AW(4), .NRD(4), .NWR(4)) bus ();
   reg_file_hs_if #(.DW(32), .AW(4), .NRD(4), .NWR(4)) bus12 ();

   reg_file_hs #(.DW(32), .DEPTH(16), .AW(4), .NRD(4), .NWR(4), .LAT(11)) u_dut (
      .clk(clk), .rst(rst), .bus(bus),
      .pc_we(pc_we), .pc_din(pc_din), .pc(pc),
      .cpsr_we(cpsr_we), .cpsr_din(cpsr_din), .cpsr(cpsr),
      .busy(busy)
   );

   reg_file_hs #(.DW(32), .DEPTH(12), .AW(4), .NRD(4), .NWR(4), .LAT(11)) u_dut12 (
      .clk(clk), .rst(rst), .bus(bus12),
      .pc_we(pc_we12), .pc_din(pc_din12), .pc(pc12),
      .cpsr_we(cpsr_we12), .cpsr_din(cpsr_din12), .cpsr(cpsr12),
      .busy(busy12)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Read on port p of the selected instance; lat counts edges from the
   // sampling edge to the commit edge, -1 on timeout.
   task automatic do_read(input bit sel, input int p, input logic [3:0] a,
                          output logic [31:0] d, output int lat, output logic ack_after);
      logic ack;
      lat = -1;
      d   = '0;
      if (sel) begin bus12.rd_addr[p*4 +: 4] = a; bus12.rd_req[p] = 1'b1; end
      else     begin bus.rd_addr[p*4 +: 4]   = a; bus.rd_req[p]   = 1'b1; end
      for (int k = 1; k <= 100; k++) begin
         tick();
         ack = sel ? bus12.rd_ack[p] : bus.rd_ack[p];
         if (ack) begin
            lat = k - 1;
            d   = sel ? bus12.rd_data[p*32 +: 32] : bus.rd_data[p*32 +: 32];
            break;
         end
      end
      if (sel) bus12.rd_req[p] = 1'b0; else bus.rd_req[p] = 1'b0;
      tick();
      ack_after = sel ? bus12.rd_ack[p] : bus.rd_ack[p];
   endtask

   task automatic do_write(input bit sel, input int p, input logic [3:0] a,
                           input logic [31:0] d, output int lat, output logic ack_after);
      logic ack;
      lat = -1;
      if (sel) begin
         bus12.wr_addr[p*4 +: 4] = a; bus12.wr_data[p*32 +: 32] = d; bus12.wr_req[p] = 1'b1;
      end else begin
         bus.wr_addr[p*4 +: 4] = a; bus.wr_data[p*32 +: 32] = d; bus.wr_req[p] = 1'b1;
      end
      for (int k = 1; k <= 100; k++) begin
         tick();
         ack = sel ? bus12.wr_ack[p] : bus.wr_ack[p];
         if (ack) begin
            lat = k - 1;
            break;
         end
      end
      if (sel) bus12.wr_req[p] = 1'b0; else bus.wr_req[p] = 1'b0;
      tick();
      ack_after = sel ? bus12.wr_ack[p] : bus.wr_ack[p];
   endtask

   task automatic test_reset();
      logic [31:0] d;
      int          lat;
      logic        aa;
      int          acks_seen;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b exp 0", busy); else n_pass++;
      n_checks++; if (pc !== 32'h0) $display("FAIL reset_pc got %h exp 0", pc); else n_pass++;
      n_checks++; if (cpsr !== 32'h0) $display("FAIL reset_cpsr got %h exp 0", cpsr); else n_pass++;
      n_checks++; if (bus.rd_data !== 128'h0) $display("FAIL reset_rd_data got %h exp 0", bus.rd_data); else n_pass++;
      n_checks++; if ({bus.rd_ack, bus.wr_ack} !== 8'h0) $display("FAIL reset_acks got %h exp 0", {bus.rd_ack, bus.wr_ack}); else n_pass++;
      n_checks++; if (busy12 !== 1'b0) $display("FAIL reset_busy12 got %0b exp 0", busy12); else n_pass++;
      acks_seen = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if ({bus.rd_ack, bus.wr_ack, bus12.rd_ack, bus12.wr_ack} != 16'h0 || busy || busy12) acks_seen++;
      end
      n_checks++; if (acks_seen !== 0) $display("FAIL idle_no_ack got %0d active cycles exp 0", acks_seen); else n_pass++;
      for (int a = 0; a < 16; a++) begin
         do_read(1'b0, a % 4, 4'(a), d, lat, aa);
         n_checks++; if (d !== 32'h0) $display("FAIL reset_R%0d got %h exp 0", a, d); else n_pass++;
      end
   endtask

   task automatic test_single_rw();
      logic [31:0] d;
      int          lat;
      logic        aa;
      do_write(1'b0, 0, 4'd5, 32'hDEADBEEF, lat, aa);
      n_checks++; if (lat !== 11) $display("FAIL wr_latency got %0d exp 11", lat); else n_pass++;
      n_checks++; if (aa !== 1'b0) $display("FAIL wr_ack_pulse got %0b exp 0", aa); else n_pass++;
      do_read(1'b0, 2, 4'd5, d, lat, aa);
      n_checks++; if (d !== 32'hDEADBEEF) $display("FAIL rd_data got %h exp deadbeef", d); else n_pass++;
      n_checks++; if (lat !== 11) $display("FAIL rd_latency got %0d exp 11", lat); else n_pass++;
      n_checks++; if (aa !== 1'b0) $display("FAIL rd_ack_pulse got %0b exp 0", aa); else n_pass++;
      n_checks++; if (bus.rd_data[2*32 +: 32] !== 32'hDEADBEEF) $display("FAIL rd_data_hold got %h exp deadbeef", bus.rd_data[2*32 +: 32]); else n_pass++;
      n_checks++; if (bus.rd_data[1*32 +: 32] !== 32'h0) $display("FAIL rd_other_port got %h exp 0", bus.rd_data[1*32 +: 32]); else n_pass++;
      do_write(1'b0, 3, 4'd0, 32'h0000_0001, lat, aa);
      do_write(1'b0, 1, 4'd15, 32'h8000_0000, lat, aa);
      do_read(1'b0, 0, 4'd0, d, lat, aa);
      n_checks++; if (d !== 32'h0000_0001) $display("FAIL rd_addr0 got %h exp 00000001", d); else n_pass++;
      do_read(1'b0, 3, 4'd15, d, lat, aa);
      n_checks++; if (d !== 32'h8000_0000) $display("FAIL rd_addr15 got %h exp 80000000", d); else n_pass++;
   endtask

   task automatic test_fairness();
      int          order [9];
      int          times [9];
      int          got;
      int          bad;
      int          t;
      logic [7:0]  acks;
      logic [31:0] d;
      int          lat;
      logic        aa;
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.rd_addr[i*4 +: 4]   = 4'(i);
         bus.wr_addr[i*4 +: 4]   = 4'(8 + i);
         bus.wr_data[i*32 +: 32] = 32'hA0 + 32'(i);
      end
      bus.rd_req = '1;
      bus.wr_req = '1;
      for (int k = 0; k < 9; k++) begin order[k] = -1; times[k] = -1; end
      tick();
      tick();
      rst = 1'b0;
      got = 0;
      bad = 0;
      t   = 0;
      while (got < 9 && t < 200) begin
         t++;
         tick();
         acks = {bus.wr_ack, bus.rd_ack};
         if (!$onehot0(acks)) bad++;
         if (acks != 8'h0) begin
            for (int b = 0; b < 8; b++) if (acks[b]) order[got] = b;
            times[got] = t;
            got++;
         end
      end
      bus.rd_req = '0;
      bus.wr_req = '0;
      tick();
      n_checks++; if (got !== 9) $display("FAIL rr_count got %0d exp 9", got); else n_pass++;
      n_checks++; if (times[0] !== 12) $display("FAIL rr_first_time got %0d exp 12", times[0]); else n_pass++;
      for (int k = 0; k < 9; k++) begin
         n_checks++; if (order[k] !== k % 8) $display("FAIL rr_order[%0d] got %0d exp %0d", k, order[k], k % 8); else n_pass++;
      end
      for (int k = 1; k < 9; k++) begin
         n_checks++; if (times[k] - times[k-1] !== 13) $display("FAIL rr_spacing[%0d] got %0d exp 13", k, times[k] - times[k-1]); else n_pass++;
      end
      n_checks++; if (bad !== 0) $display("FAIL rr_onehot got %0d multi-ack cycles exp 0", bad); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL rr_idle_after got %0b exp 0", busy); else n_pass++;
      do_read(1'b0, 3, 4'd9, d, lat, aa);
      n_checks++; if (d !== 32'hA1) $display("FAIL rr_write_landed got %h exp 000000a1", d); else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      int          lat;
      logic        aa;
      int          wr_acks;
      bus.wr_addr[1*4 +: 4]   = 4'd3;
      bus.wr_data[1*32 +: 32] = 32'h55;
      bus.wr_req[1]           = 1'b1;
      tick();
      n_checks++; if (busy !== 1'b1) $display("FAIL mid_busy got %0b exp 1", busy); else n_pass++;
      wr_acks = 0;
      repeat (3) begin tick(); if (bus.wr_ack != 4'h0) wr_acks++; end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.wr_req[1] = 1'b0;
      n_checks++; if (busy !== 1'b0) $display("FAIL mid_busy_after_rst got %0b exp 0", busy); else n_pass++;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (bus.wr_ack != 4'h0) wr_acks++;
      end
      n_checks++; if (wr_acks !== 0) $display("FAIL mid_no_ack got %0d acks exp 0", wr_acks); else n_pass++;
      do_read(1'b0, 1, 4'd3, d, lat, aa);
      n_checks++; if (d !== 32'h0) $display("FAIL mid_no_commit got %h exp 0", d); else n_pass++;
   endtask

   task automatic test_pc_cpsr();
      logic [31:0] d;
      int          lat;
      logic        aa;
      bus.wr_addr[2*4 +: 4]   = 4'd7;
      bus.wr_data[2*32 +: 32] = 32'h1234_5678;
      bus.wr_req[2]           = 1'b1;
      tick();
      pc_we    = 1'b1; pc_din   = 32'h100;
      cpsr_we  = 1'b1; cpsr_din = 32'hF000_0000;
      tick();
      n_checks++; if (pc !== 32'h100) $display("FAIL pc_load got %h exp 00000100", pc); else n_pass++;
      n_checks++; if (cpsr !== 32'hF000_0000) $display("FAIL cpsr_load got %h exp f0000000", cpsr); else n_pass++;
      pc_we   = 1'b0; pc_din   = 32'hFFFF;
      cpsr_we = 1'b0; cpsr_din = 32'h0;
      tick();
      n_checks++; if (pc !== 32'h100) $display("FAIL pc_hold got %h exp 00000100", pc); else n_pass++;
      n_checks++; if (cpsr !== 32'hF000_0000) $display("FAIL cpsr_hold got %h exp f0000000", cpsr); else n_pass++;
      lat = -1;
      for (int k = 4; k <= 100; k++) begin
         tick();
         if (bus.wr_ack[2]) begin lat = k - 1; break; end
      end
      bus.wr_req[2] = 1'b0;
      tick();
      n_checks++; if (lat !== 11) $display("FAIL pc_wr_latency got %0d exp 11", lat); else n_pass++;
      do_read(1'b0, 0, 4'd7, d, lat, aa);
      n_checks++; if (d !== 32'h1234_5678) $display("FAIL pc_wr_data got %h exp 12345678", d); else n_pass++;
   endtask

   task automatic test_out_of_range();
      logic [31:0] d;
      int          lat;
      logic        aa;
      do_write(1'b1, 0, 4'd11, 32'h11, lat, aa);
      n_checks++; if (lat !== 11) $display("FAIL oor_wr11_latency got %0d exp 11", lat); else n_pass++;
      do_write(1'b1, 1, 4'd14, 32'hCAFE, lat, aa);
      n_checks++; if (lat !== 11) $display("FAIL oor_wr14_ack got latency %0d exp 11", lat); else n_pass++;
      do_read(1'b1, 0, 4'd14, d, lat, aa);
      n_checks++; if (d !== 32'h0) $display("FAIL oor_rd14_data got %h exp 0", d); else n_pass++;
      n_checks++; if (lat !== 11) $display("FAIL oor_rd14_ack got latency %0d exp 11", lat); else n_pass++;
      do_read(1'b1, 1, 4'd2, d, lat, aa);
      n_checks++; if (d !== 32'h0) $display("FAIL oor_no_alias got %h exp 0", d); else n_pass++;
      do_read(1'b1, 2, 4'd11, d, lat, aa);
      n_checks++; if (d !== 32'h11) $display("FAIL oor_rd11 got %h exp 00000011", d); else n_pass++;
   endtask

   initial begin
      bus.rd_req   = '0; bus.rd_addr   = '0;
      bus.wr_req   = '0; bus.wr_addr   = '0; bus.wr_data   = '0;
      bus12.rd_req = '0; bus12.rd_addr = '0;
      bus12.wr_req = '0; bus12.wr_addr = '0; bus12.wr_data = '0;
      test_reset();
      test_single_rw();
      test_fairness();
      test_reset_mid();
      test_pc_cpsr();
      test_out_of_range();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
